// File: rtl/mem_arbiter.sv
// Two-to-one arbiter sharing one memory port between instruction and data requesters.
// Grant is combinational (0 cycles) and responses are forwarded in the same cycle.
// Losing or late requests wait in a per-port pending slot. Define MEM_ARBITER_RR_EN for round-robin on conflict.
package wires;

    typedef struct packed {
        logic        mem_valid;
        logic        mem_fence;
        logic        mem_instr;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;

    typedef struct packed {
        logic        mem_ready;
        logic [31:0] mem_rdata;
    } mem_out_type;

endpackage

module mem_arbiter
    import wires::*;
(
    input  logic        reset,
    input  logic        clock,
    input  mem_in_type  imem_in,
    output mem_out_type imem_out,
    input  mem_in_type  dmem_in,
    output mem_out_type dmem_out,
    output mem_in_type  mem_in,
    input  mem_out_type mem_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INSTR = 2'd1,
        DATA  = 2'd2
    } state_t;

    state_t     state;

    logic       ipend_vld;
    logic       dpend_vld;
    mem_in_type ipend;
    mem_in_type dpend;

    logic       ilive_vld;
    logic       dlive_vld;
    mem_in_type ilive;
    mem_in_type dlive;

    logic       arb_en;
    logic       data_first;
    logic       grant_i;
    logic       grant_d;
    logic       route_i;
    logic       route_d;

`ifdef MEM_ARBITER_RR_EN
    // Set when data was granted most recently; reset value favours data on the first conflict.
    logic       last_data;
    assign data_first = ~last_data;
`else
    assign data_first = 1'b1;
`endif

    // The pending slot outranks the live input so an older captured request is never skipped.
    always_comb begin
        ilive_vld = ipend_vld | imem_in.mem_valid;
        dlive_vld = dpend_vld | dmem_in.mem_valid;
        ilive     = ipend_vld ? ipend : imem_in;
        dlive     = dpend_vld ? dpend : dmem_in;
    end

    always_comb begin
        arb_en  = (state == IDLE) && !reset;
        grant_d = arb_en && dlive_vld && (!ilive_vld || data_first);
        grant_i = arb_en && ilive_vld && !grant_d;
    end

    always_comb begin
        mem_in = '0;
        if (grant_d) begin
            mem_in           = dlive;
            mem_in.mem_valid = 1'b1;
        end else if (grant_i) begin
            mem_in           = ilive;
            mem_in.mem_valid = 1'b1;
        end
    end

    // Routing includes the grant cycle itself so a zero-wait memory reaches its requester.
    always_comb begin
        route_i  = !reset && (grant_i || (state == INSTR));
        route_d  = !reset && (grant_d || (state == DATA));
        imem_out = route_i ? mem_out : '0;
        dmem_out = route_d ? mem_out : '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            ipend_vld <= 1'b0;
            dpend_vld <= 1'b0;
            ipend     <= '0;
            dpend     <= '0;
`ifdef MEM_ARBITER_RR_EN
            last_data <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state <= mem_out.mem_ready ? IDLE : DATA;
                    end else if (grant_i) begin
                        state <= mem_out.mem_ready ? IDLE : INSTR;
                    end
                end
                INSTR, DATA: begin
                    if (mem_out.mem_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // A port's input is captured only while it neither owns the bus nor is granted now.
            if (grant_i) begin
                ipend_vld <= 1'b0;
            end else if ((state != INSTR) && imem_in.mem_valid) begin
                ipend_vld <= 1'b1;
                ipend     <= imem_in;
            end

            if (grant_d) begin
                dpend_vld <= 1'b0;
            end else if ((state != DATA) && dmem_in.mem_valid) begin
                dpend_vld <= 1'b1;
                dpend     <= dmem_in;
            end

`ifdef MEM_ARBITER_RR_EN
            if (grant_d) begin
                last_data <= 1'b1;
            end else if (grant_i) begin
                last_data <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-to-one arbiter that shares the single core memory port between the instruction requester (fetch buffer) and the data requester (load/store path). It accepts `mem_in_type` requests on both sides, issues at most one transaction at a time to the shared port, and routes `mem_out_type` responses back to the owning requester. Each losing or late request is held in a per-port pending slot so neither requester needs to keep its request asserted.

## Interface
- No parameters; field widths come from `mem_in_type` / `mem_out_type` in `wires`.
- Port list:
  - `reset  in  1`: synchronous, active-high.
  - `clock  in  1`: rising-edge clock.
  - `imem_in  in  mem_in_type`: instruction request (`mem_valid`, `mem_fence`, `mem_instr`, `mem_addr[31:0]`, `mem_wdata[31:0]`, `mem_wstrb[3:0]`).
  - `imem_out  out  mem_out_type`: instruction response (`mem_ready`, `mem_rdata[31:0]`).
  - `dmem_in  in  mem_in_type`: data request.
  - `dmem_out  out  mem_out_type`: data response.
  - `mem_in  out  mem_in_type`: request to the shared memory.
  - `mem_out  in  mem_out_type`: response from the shared memory.

## Operation
- State machine `state ∈ {IDLE, INSTR, DATA}`. Reset state is IDLE.
- Pending slots `ipend` and `dpend` each hold a valid flag and the full request.
  - A port's `mem_valid=1` is captured into its slot when that port neither owns the bus nor is granted this cycle.
  - A later valid on the same port overwrites the slot; the latest request wins, which covers fetch redirect.
  - While a port owns the bus (state INSTR or DATA for that port), its `mem_valid` is ignored and not captured.
- Live request per port = the slot if it is valid, otherwise the combinational input if `mem_valid=1`. The slot has priority over the input.
- In IDLE, arbitrate between the live requests:
  - Grant the winner and drive its fields on `mem_in` with `mem_valid=1` in the same cycle.
  - Clear the winner's slot.
  - Next state is INSTR or DATA according to the winner.
  - The loser stays or becomes pending.
- In INSTR or DATA:
  - `mem_in` is all-zero, so `mem_valid=0`.
  - `mem_out` is forwarded combinationally to the owner's `*_out`.
  - The non-owner's `*_out` is `ready=0`, `rdata=0`.
  - When `mem_out.mem_ready=1`, next state is IDLE.
- `mem_fence`, `mem_instr`, `mem_wstrb` and `mem_wdata` pass through unmodified with the granted request.
- Fixed priority (default): data beats instruction on conflict.
- Reset mid-transaction: state goes to IDLE and both slots are cleared. The memory shares the same reset, so no stale response is expected.

## Timing
- Reset values: `mem_in`, `imem_out` and `dmem_out` are all fields zero.
- Grant latency is 0 cycles. A request arriving in IDLE appears on `mem_in` in the same cycle.
- Response latency: requester `mem_ready` equals memory `mem_ready` in the same cycle, with no added delay.
- Turnaround: ready in cycle T gives IDLE in T+1, and the next grant (pending or new) is issued in T+1. There is no extra bubble.
- The memory must sample the request in the cycle `mem_valid=1`. The arbiter never holds `mem_valid` high for more than one cycle per transaction.
- If `mem_ready=1` arrives in the same cycle as the grant: this is a zero-wait memory. Ready is routed to the grantee and the next state is IDLE, not busy.

## Configuration
- `MEM_ARBITER_RR_EN` defined: round-robin on conflict.
  - A `last` register records the most recently granted port.
  - On conflict, the port not equal to `last` wins.
  - `last` resets to INSTR, so data wins the first conflict.
  - Non-conflicting grants also update `last`.
- Undefined: fixed data priority as in Operation, and no `last` register.

## Test plan
- Lone fetch: `imem_in` valid with addr 0x100 in IDLE. Expect `mem_in.mem_valid=1` with addr 0x100 the same cycle. Memory ready 2 cycles later with rdata 0x00000013. Expect `imem_out.ready=1`, `rdata=0x13` in that cycle, and `dmem_out.ready=0`.
- Conflict, fixed priority: imem addr 0x200 and dmem addr 0x8000 (wstrb 0xF, wdata 0xDEADBEEF) in the same cycle.
  - Expect data issued first and the instruction request pending.
  - The instruction request is issued in the cycle after data ready, with addr 0x200.
- Conflict, `MEM_ARBITER_RR_EN`: three back-to-back conflicts. Expect grant order D, I, D, I, D, I.
- Overwrite: during a DATA transaction, imem valid with addr 0x300, then addr 0x304 one cycle later. Expect only addr 0x304 issued after data completes.
- Owner valid ignored: imem holds valid high throughout its own INSTR transaction. Expect exactly one memory transaction.
- Reset mid-transaction: assert reset in DATA with an instruction request pending. Expect all outputs zero next cycle, IDLE, and no issue of the pending request after reset deasserts.
